// File: rtl/lut_v_pkg.sv
// Shared constants and word/address types for blocks that access the lut_v table.
package lut_v_pkg;

  localparam int unsigned LUT_V_DATA_WIDTH = 16;
  localparam int unsigned LUT_V_ADDR_WIDTH = 8;
  localparam int unsigned LUT_V_MAX_REQ    = 8;

  typedef logic [LUT_V_ADDR_WIDTH-1:0] lut_v_addr_t;
  typedef logic [LUT_V_DATA_WIDTH-1:0] lut_v_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the first request at or after ptr wins.
// The result is a one-hot grant, or all zero when nothing is requesting.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  int unsigned idx;
  logic        found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lut_v_arbiter.sv
// Shares the lut_v read port among N_REQ requesters and returns each word, tagged
// one-hot, two cycles after its grant. Define LUT_V_ARB_FIXED_PRIO_EN for fixed priority.
module lut_v_arbiter
  import lut_v_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = LUT_V_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = LUT_V_ADDR_WIDTH,
  parameter int unsigned N_REQ      = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic [ADDR_WIDTH-1:0]       lut_addr,
  input  logic [DATA_WIDTH-1:0]       lut_q
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]      rr_ptr;
  logic [N_REQ-1:0]      gnt;
  logic [PTR_W-1:0]      win_idx;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic                  s1_valid;
  logic [N_REQ-1:0]      s1_tag;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  assign req_ready = gnt;

  // One-hot grant to winner index and winner address
  always_comb begin
    win_idx  = '0;
    win_addr = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        win_idx  = PTR_W'(i);
        win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

`ifdef LUT_V_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  // Pointer moves past the winner so it has lowest priority next cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (|gnt) begin
      rr_ptr <= (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end
  end
`endif

  // Stage 1 registers the LUT address, stage 2 captures the LUT word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lut_addr  <= '0;
      s1_valid  <= 1'b0;
      s1_tag    <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      s1_valid  <= |gnt;
      s1_tag    <= gnt;
      if (|gnt) begin
        lut_addr <= win_addr;
      end
      rsp_valid <= s1_valid ? s1_tag : '0;
      if (s1_valid) begin
        rsp_data <= lut_q;
      end
    end
  end

endmodule

// File: tb/tb_lut_v_arbiter.sv
// Directed bench for lut_v_arbiter with a behavioural ROM standing in for lut_v.
// Covers reset idle, single requester, contention, wrap-around and mid-flight reset.
module tb_lut_v_arbiter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  // Two-requester instance
  logic [1:0]  v2;
  logic [15:0] a2;
  logic [1:0]  rdy2, rv2;
  logic [15:0] rd2, q2;
  logic [7:0]  la2;

  // Four-requester instance for wrap-around
  logic [3:0]  v4;
  logic [31:0] a4;
  logic [3:0]  rdy4, rv4;
  logic [15:0] rd4, q4;
  logic [7:0]  la4;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [15:0] rom(input logic [7:0] a);
    if (a == 8'h3C) return 16'hA5F0;
    return {a ^ 8'h5A, a};
  endfunction

  assign q2 = rom(la2);
  assign q4 = rom(la4);

  lut_v_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .N_REQ(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(v2), .req_addr(a2), .req_ready(rdy2),
    .rsp_valid(rv2), .rsp_data(rd2), .lut_addr(la2), .lut_q(q2)
  );

  lut_v_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .N_REQ(4)) dut4 (
    .clk(clk), .reset(reset), .req_valid(v4), .req_addr(a4), .req_ready(rdy4),
    .rsp_valid(rv4), .rsp_data(rd4), .lut_addr(la4), .lut_q(q4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [7:0]  a0;
    logic [7:0]  a1;
    logic [1:0]  rdy;
    logic [1:0]  rv;
    logic [15:0] rd;
    logic [7:0]  la;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] a1,
                              input logic [1:0] rdy, input logic [1:0] rv,
                              input logic [15:0] rd, input logic [7:0] la);
    vec_t t;
    t.v = v; t.a0 = a0; t.a1 = a1; t.rdy = rdy; t.rv = rv; t.rd = rd; t.la = la;
    return t;
  endfunction

  vec_t tbl[17];
  logic [3:0] exp4_rdy[6];
  logic [7:0] exp4_la[6];
  logic [3:0] v4_seq[6];

  initial begin
    // Single requester 1 to 0x3C, then both contending, then requester 0 held twice
    tbl[0]  = mk(2'b10, 8'h00, 8'h3C, 2'b10, 2'b00, 16'h0000, 8'h00);
    tbl[1]  = mk(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 16'h0000, 8'h3C);
    tbl[2]  = mk(2'b00, 8'h00, 8'h00, 2'b00, 2'b10, 16'hA5F0, 8'h3C);
`ifdef LUT_V_ARB_FIXED_PRIO_EN
    tbl[3]  = mk(2'b11, 8'h01, 8'h02, 2'b01, 2'b00, 16'hA5F0, 8'h3C);
    tbl[4]  = mk(2'b11, 8'h01, 8'h02, 2'b01, 2'b00, 16'hA5F0, 8'h01);
    tbl[5]  = mk(2'b11, 8'h01, 8'h02, 2'b01, 2'b01, 16'h5B01, 8'h01);
    tbl[6]  = mk(2'b11, 8'h01, 8'h02, 2'b01, 2'b01, 16'h5B01, 8'h01);
    tbl[7]  = mk(2'b11, 8'h01, 8'h02, 2'b01, 2'b01, 16'h5B01, 8'h01);
    tbl[8]  = mk(2'b11, 8'h01, 8'h02, 2'b01, 2'b01, 16'h5B01, 8'h01);
    tbl[9]  = mk(2'b00, 8'h00, 8'h00, 2'b00, 2'b01, 16'h5B01, 8'h01);
    tbl[10] = mk(2'b00, 8'h00, 8'h00, 2'b00, 2'b01, 16'h5B01, 8'h01);
    tbl[11] = mk(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 16'h5B01, 8'h01);
    tbl[12] = mk(2'b01, 8'h10, 8'h00, 2'b01, 2'b00, 16'h5B01, 8'h01);
    tbl[13] = mk(2'b01, 8'h10, 8'h00, 2'b01, 2'b00, 16'h5B01, 8'h10);
`else
    tbl[3]  = mk(2'b11, 8'h01, 8'h02, 2'b01, 2'b00, 16'hA5F0, 8'h3C);
    tbl[4]  = mk(2'b11, 8'h01, 8'h02, 2'b10, 2'b00, 16'hA5F0, 8'h01);
    tbl[5]  = mk(2'b11, 8'h01, 8'h02, 2'b01, 2'b01, 16'h5B01, 8'h02);
    tbl[6]  = mk(2'b11, 8'h01, 8'h02, 2'b10, 2'b10, 16'h5802, 8'h01);
    tbl[7]  = mk(2'b11, 8'h01, 8'h02, 2'b01, 2'b01, 16'h5B01, 8'h02);
    tbl[8]  = mk(2'b11, 8'h01, 8'h02, 2'b10, 2'b10, 16'h5802, 8'h01);
    tbl[9]  = mk(2'b00, 8'h00, 8'h00, 2'b00, 2'b01, 16'h5B01, 8'h02);
    tbl[10] = mk(2'b00, 8'h00, 8'h00, 2'b00, 2'b10, 16'h5802, 8'h02);
    tbl[11] = mk(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 16'h5802, 8'h02);
    tbl[12] = mk(2'b01, 8'h10, 8'h00, 2'b01, 2'b00, 16'h5802, 8'h02);
    tbl[13] = mk(2'b01, 8'h10, 8'h00, 2'b01, 2'b00, 16'h5802, 8'h10);
`endif
    tbl[14] = mk(2'b00, 8'h00, 8'h00, 2'b00, 2'b01, 16'h4A10, 8'h10);
    tbl[15] = mk(2'b00, 8'h00, 8'h00, 2'b00, 2'b01, 16'h4A10, 8'h10);
    tbl[16] = mk(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 16'h4A10, 8'h10);

    // Four requesters: 3 alone, then all four
    v4_seq = '{4'b1000, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
`ifdef LUT_V_ARB_FIXED_PRIO_EN
    exp4_rdy = '{4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    exp4_la  = '{8'h00, 8'h43, 8'h40, 8'h40, 8'h40, 8'h40};
`else
    exp4_rdy = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp4_la  = '{8'h00, 8'h43, 8'h40, 8'h41, 8'h42, 8'h43};
`endif

    reset = 1'b0;
    v2 = '0; a2 = '0; v4 = '0; a4 = {8'h43, 8'h42, 8'h41, 8'h40};
    #1;
    chk("reset_ready", 32'(rdy2), 32'h0);
    chk("reset_rsp_valid", 32'(rv2), 32'h0);
    chk("reset_rsp_data", 32'(rd2), 32'h0);
    chk("reset_lut_addr", 32'(la2), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Idle after reset release
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("idle_ready", 32'(rdy2), 32'h0);
      chk("idle_rsp_valid", 32'(rv2), 32'h0);
      chk("idle_lut_addr", 32'(la2), 32'h0);
    end

    // Table: inputs driven at negedge, all outputs sampled 1 time unit later
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      v2 = tbl[i].v;
      a2 = {tbl[i].a1, tbl[i].a0};
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(rdy2), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_rsp_valid", i), 32'(rv2), 32'(tbl[i].rv));
      chk($sformatf("tbl%0d_rsp_data", i), 32'(rd2), 32'(tbl[i].rd));
      chk($sformatf("tbl%0d_lut_addr", i), 32'(la2), 32'(tbl[i].la));
    end

    // Mid-flight reset: grant requester 0, then reset one cycle later
    @(negedge clk);
    v2 = 2'b01; a2 = {8'h00, 8'h20};
    #1 chk("mid_grant", 32'(rdy2), 32'h1);
    @(negedge clk);
    v2 = 2'b00; reset = 1'b0;
    #1 chk("mid_rsp_valid_0", 32'(rv2), 32'h0);
    chk("mid_lut_addr", 32'(la2), 32'h0);
    @(negedge clk);
    #1 chk("mid_rsp_valid_1", 32'(rv2), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("mid_rsp_valid_2", 32'(rv2), 32'h0);
    @(negedge clk);
    v2 = 2'b11; a2 = {8'h02, 8'h01};
    #1 chk("mid_first_grant", 32'(rdy2), 32'h1);
    @(negedge clk);
    v2 = 2'b00;

    // Wrap-around on the four-requester instance
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      v4 = v4_seq[i];
      #1;
      chk($sformatf("wrap%0d_ready", i), 32'(rdy4), 32'(exp4_rdy[i]));
      chk($sformatf("wrap%0d_lut_addr", i), 32'(la4), 32'(exp4_la[i]));
    end
    @(negedge clk);
    v4 = '0;
    #1 chk("wrap_rsp_valid", 32'(rv4), {28'h0, exp4_rdy[4]});

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lut_v_arbiter.md
Name: lut_v_arbiter

Overview:
- Shares one `lut_v` read port between N_REQ encoder-side requesters, e.g. the range-update stage and the probability-adaptation stage.
- Arbitrates with a round-robin pointer and registers the granted address into the LUT.
- Captures the LUT output and returns it, tagged one-hot, to the winning requester two cycles after grant.
- Sits between the encoder pipeline stages and the `lut_v` instance it owns.

Parameters:
- DATA_WIDTH, 16, width of a LUT word (matches `lut_v`).
- ADDR_WIDTH, 8, width of a LUT address (matches `lut_v`).
- N_REQ, 2, number of requesters; legal range 2..8.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester request strobe.
- req_addr  in  N_REQ*ADDR_WIDTH  packed addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_ready  out  N_REQ  one-hot grant; a request is accepted when req_valid[i] & req_ready[i].
- rsp_valid  out  N_REQ  one-hot response strobe, one cycle wide.
- rsp_data  out  DATA_WIDTH  LUT word for the requester flagged in rsp_valid.
- lut_addr  out  ADDR_WIDTH  registered address driven to `lut_v`.addr.
- lut_q  in  DATA_WIDTH  `lut_v`.q, combinational read of lut_addr.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, lut_addr=0, rr_ptr=0, both pipeline valid/tag registers=0.
- Grant (combinational, cycle t):
  - Scan starts at rr_ptr and wraps modulo N_REQ.
  - req_ready is the one-hot of the first asserted req_valid found; all zero when no request.
  - req_ready never asserts for a requester whose req_valid is low.
- Stage 1 (edge ending t):
  - On a grant, lut_addr <= req_addr of the winner, s1_valid <= 1, s1_tag <= winner one-hot.
  - rr_ptr <= (winner+1) mod N_REQ; the wrap from N_REQ-1 goes to 0.
  - Without a grant: s1_valid <= 0; lut_addr and rr_ptr hold.
- Stage 2 (edge ending t+1):
  - rsp_data <= lut_q; rsp_valid <= s1_tag when s1_valid, else 0.
  - rsp_data holds its last value when rsp_valid=0.
- Latency and throughput:
  - Response appears at cycle t+2 relative to the accepting cycle.
  - Throughput is one grant per cycle; no back-pressure on responses (requesters must always sink).
- Requester protocol:
  - A requester may hold req_valid high across consecutive cycles; each handshake is a separate lookup.
  - req_addr must be stable while req_valid is high and req_ready is low.
- Simultaneous events:
  - All requesters active: grants rotate i, i+1, ... with no requester waiting more than N_REQ-1 cycles.
  - A single active requester is granted every cycle.
- Reset mid-operation: clears both stages immediately; in-flight lookups are dropped with no rsp_valid, and rr_ptr returns to 0.
- State is two pipeline stages plus rr_ptr; there is no multi-cycle FSM.

Optional Feature:
- Macro: LUT_V_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, requester 0 highest. rr_ptr is not implemented and is tied to 0, so starvation of higher indices is permitted.
- Undefined: round-robin as above.

Decomposition:
- Shared package `lut_v_pkg`:
  - LUT_V_DATA_WIDTH=16, LUT_V_ADDR_WIDTH=8, LUT_V_MAX_REQ=8.
  - Typedefs lut_v_addr_t and lut_v_data_t.
- One natural sub-module, `rr_arbiter`:
  - Parameter N.
  - Inputs req[N] and ptr.
  - Output gnt one-hot.
  - Purely combinational; reused by other shared-LUT blocks.
- `lut_v` itself is instantiated beside this block at the parent level, not inside it.

Test Plan:
- Reset release, no requests:
  - req_ready=0, rsp_valid=0, lut_addr=0 for 10 cycles.
- Single requester:
  - Requester 1 sends addr 0x3C once, ROM preloaded 0x3C->0xA5F0.
  - req_ready=2'b10 in that cycle; rsp_valid=2'b10 and rsp_data=0xA5F0 exactly 2 cycles later.
- Contention, N_REQ=2:
  - Both requesters held valid for 6 cycles with addr0=0x01, addr1=0x02.
  - Grants alternate 01,10,01,10,01,10; responses alternate ROM[1], ROM[2] with the same tags, offset 2 cycles.
- Wrap-around, N_REQ=4:
  - Only requester 3 is valid, then all four.
  - After granting 3, the next grant goes to 0 (rr_ptr wrapped).
- Mid-flight reset:
  - Assert reset one cycle after a grant.
  - rsp_valid stays 0 through the next 3 cycles; after release, the first grant goes to requester 0.
- LUT_V_ARB_FIXED_PRIO_EN defined, both requesters valid:
  - Requester 0 is granted every cycle and requester 1 is never granted.
